// File: rtl/addr_range_sequencer.sv
// Region address generator: a start command picks a [start, finish] pair from a
// parameter table and streams every address in it over valid/ready. Optional ADDR_SEQ_LOOP_EN.
module addr_range_sequencer #(
  parameter int NUM_REGIONS = 4,
  parameter int SEL_W       = 2,
  parameter int ADDR_W      = 8,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] START_TABLE  = {8'd120, 8'd80, 8'd40, 8'd0},
  parameter logic [NUM_REGIONS*ADDR_W-1:0] FINISH_TABLE = {8'd159, 8'd119, 8'd73, 8'd29}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SEL_W-1:0]  select,
  input  logic              abort,
`ifdef ADDR_SEQ_LOOP_EN
  input  logic              loop_en,
`endif
  input  logic              addr_ready,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_valid,
  output logic              addr_last,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              state_dbg
);

  // Handshake: a beat transfers on a rising edge where addr_valid & addr_ready are both
  // high; addr/addr_last hold while valid & !ready, and valid only drops by acceptance,
  // abort or reset.

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] start_q, start_d;
  logic [ADDR_W-1:0] finish_q, finish_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              sel_ok;
  logic [ADDR_W-1:0] lk_start, lk_finish;
  logic              wrap;
  logic              accept;
  logic              at_finish;

  // Out-of-range selects match no entry, so they never index past the table.
  always_comb begin
    sel_ok    = 1'b0;
    lk_start  = '0;
    lk_finish = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (select == SEL_W'(i)) begin
        sel_ok    = 1'b1;
        lk_start  = START_TABLE[i*ADDR_W +: ADDR_W];
        lk_finish = FINISH_TABLE[i*ADDR_W +: ADDR_W];
      end
    end
  end

`ifdef ADDR_SEQ_LOOP_EN
  assign wrap = loop_en;
`else
  assign wrap = 1'b0;
`endif

  assign accept    = (state_q == RUN) && addr_ready;
  assign at_finish = (addr_q == finish_q);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    start_d  = start_q;
    finish_d = finish_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (sel_ok && (lk_start <= lk_finish)) begin
            state_d  = RUN;
            addr_d   = lk_start;
            start_d  = lk_start;
            finish_d = lk_finish;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        // Abort outranks a simultaneous accept: that beat is discarded.
        if (abort) begin
          state_d = IDLE;
        end else if (accept) begin
          if (!at_finish) begin
            addr_d = addr_q + 1'b1;
          end else if (wrap) begin
            addr_d = start_q;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      start_q  <= '0;
      finish_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      start_q  <= start_d;
      finish_q <= finish_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign addr       = addr_q;
  assign addr_valid = (state_q == RUN);
  assign busy       = (state_q == RUN);
  assign addr_last  = addr_valid && at_finish;
  assign done       = done_q;
  assign err        = err_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_addr_range_sequencer.sv
// Bench for addr_range_sequencer: a default-table instance plus a 3-region instance holding
// a reversed entry and a region ending at 255; expected beats come from the region tables.
module tb_addr_range_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] select;
  logic       abort;
  logic       loop_en;
  logic       addr_ready;
  int         inst;

  logic [7:0] a_addr, b_addr;
  logic a_valid, a_last, a_busy, a_done, a_err, a_st;
  logic b_valid, b_last, b_busy, b_done, b_err, b_st;

  logic [7:0] o_addr;
  logic o_valid, o_last, o_busy, o_done, o_err, o_st;

  int total;
  int bad;
  logic [7:0] exp_q[$];

  int st_tab[2][4];
  int fn_tab[2][4];

  addr_range_sequencer dut_a (
    .clk(clk), .rst(rst), .start(start && (inst == 0)), .select(select), .abort(abort),
`ifdef ADDR_SEQ_LOOP_EN
    .loop_en(loop_en),
`endif
    .addr_ready(addr_ready), .addr(a_addr), .addr_valid(a_valid), .addr_last(a_last),
    .busy(a_busy), .done(a_done), .err(a_err), .state_dbg(a_st)
  );

  addr_range_sequencer #(
    .NUM_REGIONS(3), .SEL_W(2), .ADDR_W(8),
    .START_TABLE({8'd50, 8'd250, 8'd0}),
    .FINISH_TABLE({8'd40, 8'd255, 8'd29})
  ) dut_b (
    .clk(clk), .rst(rst), .start(start && (inst == 1)), .select(select), .abort(abort),
`ifdef ADDR_SEQ_LOOP_EN
    .loop_en(loop_en),
`endif
    .addr_ready(addr_ready), .addr(b_addr), .addr_valid(b_valid), .addr_last(b_last),
    .busy(b_busy), .done(b_done), .err(b_err), .state_dbg(b_st)
  );

  always_comb begin
    o_addr  = (inst == 1) ? b_addr  : a_addr;
    o_valid = (inst == 1) ? b_valid : a_valid;
    o_last  = (inst == 1) ? b_last  : a_last;
    o_busy  = (inst == 1) ? b_busy  : a_busy;
    o_done  = (inst == 1) ? b_done  : a_done;
    o_err   = (inst == 1) ? b_err   : a_err;
    o_st    = (inst == 1) ? b_st    : a_st;
  end

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_addr"}, 32'(o_addr), 0);
    chk({tag, "_valid"}, 32'(o_valid), 0);
    chk({tag, "_last"}, 32'(o_last), 0);
    chk({tag, "_busy"}, 32'(o_busy), 0);
    chk({tag, "_done"}, 32'(o_done), 0);
    chk({tag, "_err"}, 32'(o_err), 0);
  endtask

  // ready_mode: 0 always ready, 1 toggling, 2 random.
  // kill: 0 none, 1 abort, 2 reset, applied when kill_at beats have been accepted.
  task automatic run_region(input int sel, input int ready_mode, input int passes,
                            input int kill, input int kill_at);
    int st, fn, len, n_acc, cyc;
    logic rdy;
    st = st_tab[inst][sel];
    fn = fn_tab[inst][sel];
    len = fn - st + 1;
    exp_q.delete();
    for (int p = 0; p <= passes; p++)
      for (int a = st; a <= fn; a++) exp_q.push_back(8'(a));
    @(negedge clk);
    start = 1'b1;
    select = 2'(sel);
    @(negedge clk);
    start = 1'b0;
    n_acc = 0;
    cyc = 0;
    while (exp_q.size() > 0) begin
      chk("run_valid", 32'(o_valid), 1);
      chk("run_addr", 32'(o_addr), 32'(exp_q[0]));
      chk("run_last", 32'(o_last), (int'(exp_q[0]) == fn) ? 1 : 0);
      chk("run_busy", 32'(o_busy), 1);
      chk("run_done", 32'(o_done), 0);
      if (kill != 0 && n_acc == kill_at) begin
        start = 1'b0;
        addr_ready = 1'b1;
        if (kill == 1) abort = 1'b1; else rst = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        rst = 1'b0;
        addr_ready = 1'b0;
        chk("kill_valid", 32'(o_valid), 0);
        chk("kill_busy", 32'(o_busy), 0);
        chk("kill_done", 32'(o_done), 0);
        chk("kill_last", 32'(o_last), 0);
        if (kill == 2) chk_idle_zero("rst_run");
        @(negedge clk);
        chk("kill_done2", 32'(o_done), 0);
        chk("kill_valid2", 32'(o_valid), 0);
        return;
      end
      case (ready_mode)
        0: rdy = 1'b1;
        1: rdy = (cyc % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      addr_ready = rdy;
      loop_en = (exp_q.size() > len);
      // stray start requests while running must be ignored
      start = 1'($urandom_range(0, 1));
      select = 2'($urandom_range(0, 3));
      @(negedge clk);
      if (rdy) begin
        void'(exp_q.pop_front());
        n_acc++;
      end
      cyc++;
      if (cyc > 5000) begin
        chk("run_timeout", 0, 1);
        start = 1'b0;
        return;
      end
    end
    start = 1'b0;
    addr_ready = 1'b0;
    loop_en = 1'b0;
    chk("end_valid", 32'(o_valid), 0);
    chk("end_done", 32'(o_done), 1);
    chk("end_busy", 32'(o_busy), 0);
    chk("end_err", 32'(o_err), 0);
    @(negedge clk);
    chk("end_done_pulse", 32'(o_done), 0);
  endtask

  task automatic bad_start(input int sel);
    @(negedge clk);
    start = 1'b1;
    select = 2'(sel);
    @(negedge clk);
    start = 1'b0;
    chk("err_pulse", 32'(o_err), 1);
    chk("err_valid", 32'(o_valid), 0);
    chk("err_busy", 32'(o_busy), 0);
    chk("err_state", 32'(o_st), 0);
    chk("err_done", 32'(o_done), 0);
    @(negedge clk);
    chk("err_clear", 32'(o_err), 0);
    chk("err_valid2", 32'(o_valid), 0);
  endtask

  initial begin
    total = 0;
    bad = 0;
    st_tab[0] = '{0, 40, 80, 120};
    fn_tab[0] = '{29, 73, 119, 159};
    st_tab[1] = '{0, 250, 50, 0};
    fn_tab[1] = '{29, 255, 40, 0};
    inst = 0;
    rst = 1'b1;
    start = 1'b0;
    select = '0;
    abort = 1'b0;
    loop_en = 1'b0;
    addr_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle_zero("reset_a");
    inst = 1;
    chk_idle_zero("reset_b");
    inst = 0;
    rst = 1'b0;

    // full region at full rate, then toggling ready
    run_region(0, 0, 0, 0, 0);
    run_region(1, 1, 0, 0, 0);
    // abort at address 95, then a fresh run of region 3
    run_region(2, 0, 0, 1, 15);
    run_region(3, 0, 0, 0, 0);
    // reset at address 130 during region 3
    run_region(3, 2, 0, 2, 10);
    run_region(0, 2, 0, 0, 0);

    // invalid select and reversed table entry, then a region ending at 255
    inst = 1;
    bad_start(3);
    bad_start(2);
    run_region(1, 0, 0, 0, 0);
    run_region(1, 2, 0, 0, 0);
    run_region(0, 2, 0, 1, 7);
    inst = 0;

    for (int k = 0; k < 6; k++) begin
      run_region(int'($urandom_range(0, 3)), 2, 0, 0, 0);
    end
    run_region(int'($urandom_range(0, 3)), 2, 0, 1, int'($urandom_range(0, 20)));

`ifdef ADDR_SEQ_LOOP_EN
    // two wraps back to 0 with no gap, then a normal finish; then abort inside a loop
    run_region(0, 0, 2, 0, 0);
    run_region(0, 2, 3, 1, 45);
    run_region(1, 2, 0, 0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
